// File: rtl/i2s_pkg.sv
// Shared I2S definitions: default word width and receiver state encoding.
// Used by both the receive and transmit paths.
package i2s_pkg;

  localparam int DATA_BIT_DEF = 16;

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_LEFT  = 2'd1,
    ST_RIGHT = 2'd2
  } rx_state_e;

endpackage

// File: rtl/i2s_rx_sync.sv
// Pin synchronizers for sclk/lrclk/sd, all the same depth so they stay
// aligned, plus a one-cycle strobe on each synchronized sclk rising edge.
module i2s_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic rx_sclk,
  input  logic rx_lrclk,
  input  logic rx_sd,
  output logic lrclk,
  output logic sd,
  output logic sclk_rise
);

  logic [SYNC_STAGES-1:0] sclk_ff;
  logic [SYNC_STAGES-1:0] lr_ff;
  logic [SYNC_STAGES-1:0] sd_ff;
  logic                   sclk_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_ff <= '0;
      lr_ff   <= '0;
      sd_ff   <= '0;
      sclk_q  <= 1'b0;
    end else begin
      sclk_ff <= (sclk_ff << 1) | SYNC_STAGES'(rx_sclk);
      lr_ff   <= (lr_ff << 1) | SYNC_STAGES'(rx_lrclk);
      sd_ff   <= (sd_ff << 1) | SYNC_STAGES'(rx_sd);
      sclk_q  <= sclk_ff[SYNC_STAGES-1];
    end
  end

  assign lrclk     = lr_ff[SYNC_STAGES-1];
  assign sd        = sd_ff[SYNC_STAGES-1];
  assign sclk_rise = sclk_ff[SYNC_STAGES-1] & ~sclk_q;

endmodule

// File: rtl/i2s_rx.sv
// I2S receiver: oversamples the bit clock, deserializes left/right words
// and presents complete stereo pairs on a valid/ready output.
module i2s_rx
  import i2s_pkg::*;
#(
  parameter int DATA_BIT    = DATA_BIT_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                rx_sclk,
  input  logic                rx_lrclk,
  input  logic                rx_sd,
  output logic [DATA_BIT-1:0] audio_l,
  output logic [DATA_BIT-1:0] audio_r,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic                overrun,
  output logic                frame_err,
  input  logic                err_clr
);

  localparam int CW = $clog2(DATA_BIT + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DATA_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_BIT - 1);

  logic                lrclk_s;
  logic                sd_s;
  logic                rise;

  rx_state_e           state;
  rx_state_e           state_nxt;
  logic                lr_prev;
  logic [CW-1:0]       cnt;
  logic [DATA_BIT-1:0] shreg;
  logic [DATA_BIT-1:0] sh_nxt;
  logic [DATA_BIT-1:0] hold;
  logic                left_ok;

  logic                lr_up;
  logic                lr_dn;
  logic                short_w;
  logic                last_b;
  logic                cnt_clr;
  logic                shift_en;
  logic                left_load;
  logic                pair_load;
  logic                ferr_set;
  logic                lok_clr;

  i2s_rx_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .rx_sclk  (rx_sclk),
    .rx_lrclk (rx_lrclk),
    .rx_sd    (rx_sd),
    .lrclk    (lrclk_s),
    .sd       (sd_s),
    .sclk_rise(rise)
  );

  assign lr_up   = ~lr_prev & lrclk_s;
  assign lr_dn   = lr_prev & ~lrclk_s;
  assign short_w = cnt < CNT_FULL;
  assign last_b  = cnt == CNT_LAST;
  assign sh_nxt  = (shreg << 1) | DATA_BIT'(sd_s);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_SYNC;
    else          state <= state_nxt;
  end

  // The bit seen on the lrclk-change edge is the I2S delay slot: dropped.
  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    shift_en  = 1'b0;
    left_load = 1'b0;
    pair_load = 1'b0;
    ferr_set  = 1'b0;
    lok_clr   = 1'b0;
    if (rise) begin
      unique case (state)
        ST_SYNC: begin
          if (lr_dn) begin
            state_nxt = ST_LEFT;
            cnt_clr   = 1'b1;
          end
        end
        ST_LEFT: begin
          if (lr_up) begin
            state_nxt = ST_RIGHT;
            cnt_clr   = 1'b1;
            ferr_set  = short_w;
            lok_clr   = short_w;
          end else if (short_w) begin
            shift_en  = 1'b1;
            left_load = last_b;
          end
        end
        ST_RIGHT: begin
          if (lr_dn) begin
            state_nxt = ST_LEFT;
            cnt_clr   = 1'b1;
            ferr_set  = short_w;
          end else if (short_w) begin
            shift_en  = 1'b1;
            pair_load = last_b & left_ok;
          end
        end
        default: state_nxt = ST_SYNC;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lr_prev <= 1'b0;
      cnt     <= '0;
      shreg   <= '0;
      hold    <= '0;
      left_ok <= 1'b0;
    end else begin
      if (rise) lr_prev <= lrclk_s;
      if (cnt_clr)       cnt <= '0;
      else if (shift_en) cnt <= cnt + 1'b1;
      if (shift_en)  shreg <= sh_nxt;
      if (left_load) hold  <= sh_nxt;
      if (left_load)                 left_ok <= 1'b1;
      else if (lok_clr || pair_load) left_ok <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      audio_l   <= '0;
      audio_r   <= '0;
      rd_valid  <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (pair_load) begin
        audio_l  <= hold;
        audio_r  <= sh_nxt;
        rd_valid <= 1'b1;
      end else if (rd_ready) begin
        rd_valid <= 1'b0;
      end
      if (pair_load && rd_valid && !rd_ready) overrun <= 1'b1;
      else if (err_clr)                       overrun <= 1'b0;
      if (ferr_set)     frame_err <= 1'b1;
      else if (err_clr) frame_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_i2s_rx.sv
// Scoreboard bench for i2s_rx: a slot-level I2S model predicts pairs and
// sticky flags; a monitor pops expectations whenever a pair is accepted.
module tb_i2s_rx;

  localparam int DW = 16;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          rx_sclk = 1'b0;
  logic          rx_lrclk = 1'b0;
  logic          rx_sd = 1'b0;
  logic          rd_ready = 1'b1;
  logic          err_clr = 1'b0;
  logic [DW-1:0] audio_l;
  logic [DW-1:0] audio_r;
  logic          rd_valid;
  logic          overrun;
  logic          frame_err;

  int n_chk = 0;
  int n_pass = 0;

  typedef struct {
    logic [DW-1:0] l;
    logic [DW-1:0] r;
  } pair_t;

  pair_t         exp_q[$];
  bit            m_prev;
  bit            m_synced;
  bit            m_lok;
  bit            m_ovr;
  bit            m_ferr;
  logic [DW-1:0] m_hold;
  event          lat_ev;

  always #5 clk = ~clk;

  i2s_rx #(
    .DATA_BIT   (DW),
    .SYNC_STAGES(SS)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .rx_sclk  (rx_sclk),
    .rx_lrclk (rx_lrclk),
    .rx_sd    (rx_sd),
    .audio_l  (audio_l),
    .audio_r  (audio_r),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .overrun  (overrun),
    .frame_err(frame_err),
    .err_clr  (err_clr)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else
      n_pass++;
  endtask

  always @(negedge clk) begin
    pair_t p;
    if (reset_n && rd_valid && rd_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious rd_valid", 1, 0);
      end else begin
        p = exp_q.pop_front();
        check("audio_l", audio_l, p.l);
        check("audio_r", audio_r, p.r);
      end
    end
  end

  always begin
    bit seen;
    @(lat_ev);
    seen = 0;
    for (int k = 0; k <= SS + 3; k++) begin
      @(negedge clk);
      if (rd_valid) begin
        seen = 1;
        break;
      end
    end
    check("rd_valid latency", seen, 1);
  end

  task automatic model_reset();
    m_prev = 0;
    m_synced = 0;
    m_lok = 0;
    m_ovr = 0;
    m_ferr = 0;
    exp_q.delete();
  endtask

  // A slot carries its word in bits 1..DW; bit 0 is the I2S delay bit.
  task automatic model_slot(input bit lr, input logic [DW-1:0] data,
                            input int nbits, output bit pushed);
    bit    full;
    pair_t p;
    pushed = 0;
    full = nbits >= DW + 1;
    if (lr == m_prev) return;
    if (!m_synced) begin
      m_synced = m_prev && !lr;
      m_prev = lr;
      if (!m_synced) return;
    end
    m_prev = lr;
    if (!full) m_ferr = 1;
    if (!lr) begin
      m_lok = full;
      if (full) m_hold = data;
    end else if (full && m_lok) begin
      m_lok = 0;
      p.l = m_hold;
      p.r = data;
      if (!rd_ready && exp_q.size() > 0) begin
        void'(exp_q.pop_back());
        m_ovr = 1;
      end
      exp_q.push_back(p);
      pushed = rd_ready;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #2;
    check("reset audio_l", audio_l, 0);
    check("reset audio_r", audio_r, 0);
    check("reset rd_valid", rd_valid, 0);
    check("reset overrun", overrun, 0);
    check("reset frame_err", frame_err, 0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic send_slot(input bit lr, input logic [DW-1:0] data,
                           input int nbits, input int h,
                           input int rst_at);
    bit   arm;
    logic b;
    if (rst_at >= 0) model_reset();
    model_slot(lr, data, nbits, arm);
    for (int i = 0; i < nbits; i++) begin
      b = 1'($urandom_range(0, 1));
      if (i >= 1 && i <= DW) b = data[DW-i];
      @(posedge clk);
      #1;
      rx_sclk = 1'b0;
      rx_lrclk = lr;
      rx_sd = b;
      if (i == rst_at) do_reset();
      repeat (h) @(posedge clk);
      #1 rx_sclk = 1'b1;
      if (arm && i == DW) ->lat_ev;
      repeat (h - 1) @(posedge clk);
    end
  endtask

  task automatic frame(input logic [DW-1:0] l, input logic [DW-1:0] r,
                       input int nl, input int nr, input int h);
    send_slot(1'b0, l, nl, h, -1);
    send_slot(1'b1, r, nr, h, -1);
  endtask

  task automatic check_flags(input string tag);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check({tag, " frame_err"}, frame_err, m_ferr);
    check({tag, " overrun"}, overrun, m_ovr);
  endtask

  task automatic pulse_clr();
    @(posedge clk);
    #1 err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
    m_ovr = 0;
    m_ferr = 0;
  endtask

  initial begin
    model_reset();
    #1 do_reset();

    // Stream joins mid right slot; the first full pair follows.
    send_slot(1'b1, 16'h0BAD, 9, 16, -1);
    frame(16'hA5C3, 16'h5A3C, 32, 32, 16);
    check_flags("basic");

    rd_ready = 1'b0;
    frame(16'h1111, 16'h2222, 32, 32, 16);
    frame(16'h3333, 16'h4444, 32, 32, 16);
    check_flags("overrun");
    rd_ready = 1'b1;
    repeat (4) @(posedge clk);
    pulse_clr();
    check_flags("overrun cleared");

    frame(16'hDEAD, 16'hBEEF, 10, 32, 16);
    frame(16'h1357, 16'h2468, 32, 32, 16);
    check_flags("truncated");
    pulse_clr();
    check_flags("trunc cleared");

    frame(16'hFACE, 16'hCAFE, 8, 32, 16);
    send_slot(1'b0, 16'h7777, 32, 16, -1);
    send_slot(1'b1, 16'h8888, 32, 16, 8);
    frame(16'h9ABC, 16'hDEF0, 32, 32, 16);
    check_flags("post reset");

    frame(16'h0F0F, 16'hF0F0, 17, 24, 4);
    frame(16'h8001, 16'h7FFE, 24, 17, 4);
    check_flags("fast clk");

    for (int n = 0; n < 20; n++) begin
      int nl;
      int nr;
      nl = $urandom_range(0, 7) == 0 ? $urandom_range(4, 16)
                                     : $urandom_range(17, 32);
      nr = $urandom_range(0, 7) == 0 ? $urandom_range(4, 16)
                                     : $urandom_range(17, 32);
      frame(DW'($urandom), DW'($urandom), nl, nr, $urandom_range(4, 12));
    end
    frame(DW'($urandom), DW'($urandom), 32, 32, 8);
    check_flags("random");

    repeat (50) @(posedge clk);
    check("queue drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
